// File: rtl/gf180mcu_fd_sc_mcu7t5v0__setn_seq.sv
// Round-robin preset sequencer for CLKN/SETN flop banks.
// Serves one bank at a time: gate clock, pulse SETN low, recover, ungate.
module gf180mcu_fd_sc_mcu7t5v0__setn_seq #(
    parameter int NBANK     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GUARD_CYC = 1
) (
    input  logic             CLKN,
    input  logic             RN,
    input  logic [NBANK-1:0] REQ,
    output logic [NBANK-1:0] GNT,
    output logic [NBANK-1:0] SETN_OUT,
    output logic [NBANK-1:0] CKEN_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int MAXC = (PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(NBANK);

    localparam logic [CW-1:0] GRD_LD = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] PLS_LD = CW'(PULSE_CYC - 1);
    localparam logic [BW-1:0] LAST   = BW'(NBANK - 1);

    localparam logic [2:0] RSYNC   = 3'd0;
    localparam logic [2:0] RELEASE = 3'd1;
    localparam logic [2:0] IDLE    = 3'd2;
    localparam logic [2:0] GATE    = 3'd3;
    localparam logic [2:0] ASSERT  = 3'd4;
    localparam logic [2:0] RECOVER = 3'd5;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    ptr;
    logic [BW-1:0]    bank;
    logic             sync1;
    logic [NBANK-1:0] gnt_q;
    logic [NBANK-1:0] setn_q;
    logic [NBANK-1:0] cken_q;
    logic             busy_q;
    logic             done_q;

    logic [BW-1:0]    pick;
    logic [BW-1:0]    idx;
    logic             hit;

    // First requesting bank at or after the pointer, wrapping around.
    always_comb begin
        pick = '0;
        idx  = '0;
        hit  = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            idx = BW'((int'(ptr) + i) % NBANK);
            if (!hit && REQ[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    // Sequencer; the RSYNC->RELEASE state flop is the second sync stage.
    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            state  <= RSYNC;
            cnt    <= '0;
            ptr    <= '0;
            bank   <= '0;
            sync1  <= 1'b0;
            gnt_q  <= '0;
            setn_q <= '0;
            cken_q <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                RSYNC: begin
                    sync1 <= 1'b1;
                    if (sync1) begin
                        state  <= RELEASE;
                        setn_q <= '1;
                        cnt    <= GRD_LD;
                    end
                end
                RELEASE: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        cken_q <= '1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (|REQ) begin
                        state        <= GATE;
                        bank         <= pick;
                        gnt_q        <= '0;
                        gnt_q[pick]  <= 1'b1;
                        cken_q[pick] <= 1'b0;
                        busy_q       <= 1'b1;
                        cnt          <= GRD_LD;
                    end
                end
                GATE: begin
                    if (cnt == '0) begin
                        state        <= ASSERT;
                        setn_q[bank] <= 1'b0;
                        cnt          <= PLS_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt == '0) begin
                        state        <= RECOVER;
                        setn_q[bank] <= 1'b1;
                        cnt          <= GRD_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state        <= IDLE;
                        cken_q[bank] <= 1'b1;
                        gnt_q        <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        ptr          <= (bank == LAST) ? '0 : bank + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= RSYNC;
                    sync1  <= 1'b0;
                    setn_q <= '0;
                    cken_q <= '0;
                    gnt_q  <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign GNT      = gnt_q;
    assign SETN_OUT = setn_q;
    assign CKEN_OUT = cken_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__setn_seq.sv
// Scoreboard bench for the SETN preset sequencer.
// Grants and DONE pulses are checked against a queue of expected events.
module tb_gf180mcu_fd_sc_mcu7t5v0__setn_seq;

    logic       CLKN;
    logic       RN;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [3:0] SETN_OUT;
    logic [3:0] CKEN_OUT;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] gnt;
    } exp_t;

    exp_t sb[$];

    gf180mcu_fd_sc_mcu7t5v0__setn_seq #(
        .NBANK(4),
        .PULSE_CYC(2),
        .GUARD_CYC(1)
    ) dut (
        .CLKN(CLKN),
        .RN(RN),
        .REQ(REQ),
        .GNT(GNT),
        .SETN_OUT(SETN_OUT),
        .CKEN_OUT(CKEN_OUT),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    initial begin
        CLKN = 1'b1;
        forever #5 CLKN = ~CLKN;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge CLKN);
        #1;
    endtask

    task automatic push(input bit d, input logic [3:0] g);
        exp_t e;
        e.is_done = d;
        e.gnt     = g;
        sb.push_back(e);
    endtask

    // Monitor: pop expected events on grant rise and DONE pulse.
    logic [3:0] prev_gnt = 4'h0;
    always @(negedge CLKN) begin
        exp_t e;
        #2;
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexp_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_done_kind", {31'd0, e.is_done}, 32'd1);
                chk("sb_done_gnt", {28'd0, GNT}, 32'h0);
                chk("sb_done_cken", {28'd0, CKEN_OUT}, 32'hF);
                chk("sb_done_setn", {28'd0, SETN_OUT}, 32'hF);
            end
        end
        if (GNT !== 4'h0 && prev_gnt === 4'h0) begin
            if (sb.size() == 0) begin
                chk("sb_unexp_gnt", {28'd0, GNT}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_gnt_kind", {31'd0, e.is_done}, 32'd0);
                chk("sb_gnt", {28'd0, GNT}, {28'd0, e.gnt});
                chk("sb_gnt_cken", {28'd0, CKEN_OUT}, {28'd0, ~e.gnt});
                chk("sb_gnt_setn", {28'd0, SETN_OUT}, 32'hF);
            end
        end
        prev_gnt = GNT;
        if (RN === 1'b1 && SETN_OUT !== 4'h0) begin
            chk("setn_onehot", ($countones(~SETN_OUT) <= 1) ? 32'd1 : 32'd0,
                32'd1);
        end
    end

    task automatic release_check(input string tag);
        tick;
        chk({tag, "_e1_setn"}, {28'd0, SETN_OUT}, 32'h0);
        tick;
        chk({tag, "_e2_setn"}, {28'd0, SETN_OUT}, 32'hF);
        chk({tag, "_e2_cken"}, {28'd0, CKEN_OUT}, 32'h0);
        chk({tag, "_e2_busy"}, {31'd0, BUSY}, 32'd1);
        tick;
        chk({tag, "_e3_cken"}, {28'd0, CKEN_OUT}, 32'hF);
        chk({tag, "_e3_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        RN  = 1'b1;
        REQ = 4'h0;
        #1 RN = 1'b0;
        repeat (3) tick;
        chk("rst_setn", {28'd0, SETN_OUT}, 32'h0);
        chk("rst_cken", {28'd0, CKEN_OUT}, 32'h0);
        chk("rst_busy", {31'd0, BUSY}, 32'd1);
        chk("rst_gnt", {28'd0, GNT}, 32'h0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        RN = 1'b1;
        release_check("rel");

        // Simultaneous requests from pointer 0
        for (int k = 0; k < 5; k++) begin
            push(1'b0, 4'h1 << (k % 4));
            push(1'b1, 4'h0);
        end
        REQ = 4'hF;
        tick;
        chk("sim_g0", {28'd0, GNT}, 32'h1);
        tick;
        tick;
        chk("sim_setn0", {28'd0, SETN_OUT}, 32'hE);
        repeat (3) tick;
        chk("sim_g1", {28'd0, GNT}, 32'h2);
        repeat (5) tick;
        chk("sim_g2", {28'd0, GNT}, 32'h4);
        repeat (5) tick;
        chk("sim_g3", {28'd0, GNT}, 32'h8);
        repeat (5) tick;
        chk("sim_g4", {28'd0, GNT}, 32'h1);
        REQ = 4'h0;
        repeat (4) tick;
        chk("sim_done", {31'd0, DONE}, 32'd1);
        tick;
        chk("sim_idle_busy", {31'd0, BUSY}, 32'd0);

        // Single request, detailed timing
        push(1'b0, 4'h4);
        push(1'b1, 4'h0);
        REQ = 4'h4;
        tick;
        chk("one_gnt", {28'd0, GNT}, 32'h4);
        chk("one_cken", {28'd0, CKEN_OUT}, 32'hB);
        chk("one_setn_e0", {28'd0, SETN_OUT}, 32'hF);
        chk("one_busy", {31'd0, BUSY}, 32'd1);
        REQ = 4'h0;
        tick;
        chk("one_setn_e1", {28'd0, SETN_OUT}, 32'hB);
        tick;
        chk("one_setn_e2", {28'd0, SETN_OUT}, 32'hB);
        tick;
        chk("one_setn_e3", {28'd0, SETN_OUT}, 32'hF);
        chk("one_cken_e3", {28'd0, CKEN_OUT}, 32'hB);
        tick;
        chk("one_cken_e4", {28'd0, CKEN_OUT}, 32'hF);
        chk("one_done_e4", {31'd0, DONE}, 32'd1);
        chk("one_gnt_e4", {28'd0, GNT}, 32'h0);
        tick;
        chk("one_done_e5", {31'd0, DONE}, 32'd0);

        // Fairness: bank 0 held, bank 2 joins
        push(1'b0, 4'h1);
        push(1'b1, 4'h0);
        push(1'b0, 4'h4);
        push(1'b1, 4'h0);
        push(1'b0, 4'h1);
        push(1'b1, 4'h0);
        REQ = 4'h1;
        tick;
        chk("fair_g0", {28'd0, GNT}, 32'h1);
        tick;
        REQ = 4'h5;
        repeat (4) tick;
        chk("fair_g1", {28'd0, GNT}, 32'h4);
        repeat (5) tick;
        chk("fair_g2", {28'd0, GNT}, 32'h1);
        REQ = 4'h0;
        repeat (4) tick;
        chk("fair_done", {31'd0, DONE}, 32'd1);
        tick;

        // Request dropped during GATE
        push(1'b0, 4'h8);
        push(1'b1, 4'h0);
        REQ = 4'h8;
        tick;
        chk("drop_gnt", {28'd0, GNT}, 32'h8);
        REQ = 4'h0;
        repeat (4) tick;
        chk("drop_done", {31'd0, DONE}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("drop_no_regnt", {28'd0, GNT}, 32'h0);
        end

        // Reset during ASSERT of bank 1
        push(1'b0, 4'h2);
        REQ = 4'h2;
        tick;
        chk("mr_gnt", {28'd0, GNT}, 32'h2);
        REQ = 4'h0;
        tick;
        chk("mr_assert", {28'd0, SETN_OUT}, 32'hD);
        #2 RN = 1'b0;
        #1;
        chk("mr_setn", {28'd0, SETN_OUT}, 32'h0);
        chk("mr_cken", {28'd0, CKEN_OUT}, 32'h0);
        chk("mr_gnt0", {28'd0, GNT}, 32'h0);
        chk("mr_busy", {31'd0, BUSY}, 32'd1);
        chk("mr_done", {31'd0, DONE}, 32'd0);
        repeat (2) tick;
        RN = 1'b1;
        release_check("mrel");
        repeat (3) tick;
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
